// File: rtl/decoder_3_to_8_seq_if.sv
// ---------------------------------------------------------------------------
// decoder_3_to_8_seq_if
// Bundles the code-input handshake and the decoded line outputs of the
// sequenced 3-to-8 decoder.
//   in_valid  : code on in_code is offered this cycle      (master -> slave)
//   in_ready  : decoder buffer can take a code             (slave  -> master)
//   in_code   : line index 0..7 to activate                (master -> slave)
//   enable    : permits the decoder to start new pulses    (master -> slave)
//   out_lines : registered one-hot line activations        (slave  -> master)
//   out_valid : high while a pulse is being driven         (slave  -> master)
//   busy      : codes buffered or a pulse/gap in progress  (slave  -> master)
// ---------------------------------------------------------------------------
interface decoder_3_to_8_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       enable;
    logic [7:0] out_lines;
    logic       out_valid;
    logic       busy;

    // Producer side: offers codes and watches the line outputs
    modport master (
        output in_valid, in_code, enable,
        input  in_ready, out_lines, out_valid, busy
    );

    // Decoder side
    modport slave (
        input  in_valid, in_code, enable,
        output in_ready, out_lines, out_valid, busy
    );
endinterface

// File: rtl/decoder_3_to_8_seq.sv
// ---------------------------------------------------------------------------
// decoder_3_to_8_seq
// Buffers 3-bit line codes in a small FIFO and replays each one as a timed
// one-hot pulse on out_lines (HOLD_CYCLES long), optionally followed by an
// all-zero gap of GAP_CYCLES cycles.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset; aborts any pulse, drops codes
//   lineIf : decoder_3_to_8_seq_if slave modport (handshake + line outputs)
// ---------------------------------------------------------------------------
module decoder_3_to_8_seq #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    decoder_3_to_8_seq_if.slave   lineIf
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GAP
    } state_t;

    state_t        state_q;
    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q;
    logic [PW-1:0] rdPtr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [HW-1:0] holdCnt_q;
    logic [GW-1:0] gapCnt_q;
    logic [7:0]    outLines_q;
    logic          outValid_q;

    logic          fifoEmpty;
    logic          fifoFull;
    logic          push;
    logic          pop;
    logic          canLaunch;
    logic [2:0]    headCode;

    // Full/empty come only from the registered count, so a pop in the same
    // cycle never opens in_ready for a full buffer.
    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == FULL_COUNT);
    assign push      = lineIf.in_valid && !fifoFull;
    assign canLaunch = !fifoEmpty && lineIf.enable;
    assign headCode  = mem_q[rdPtr_q];

    // Launch decisions: a code is popped only at the points where a new pulse
    // may start -- from IDLE, at the end of a gap, or at the end of a hold
    // when there is no gap to insert.
    always_comb begin
        pop = 1'b0;
        case (state_q)
            IDLE:    pop = canLaunch;
            DRIVE:   pop = (holdCnt_q == '0) && (GAP_CYCLES == 0) && canLaunch;
            GAP:     pop = (gapCnt_q == '0) && canLaunch;
            default: pop = 1'b0;
        endcase
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Code storage; contents need no reset since the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= lineIf.in_code;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    // Pulse sequencer with registered line outputs. A launch registers the
    // one-hot line and loads the hold counter so the line stays up for
    // exactly HOLD_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            holdCnt_q  <= '0;
            gapCnt_q   <= '0;
            outLines_q <= 8'h00;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        outLines_q <= 8'b1 << headCode;
                        outValid_q <= 1'b1;
                        holdCnt_q  <= HOLD_LOAD;
                        state_q    <= DRIVE;
                    end else begin
                        outLines_q <= 8'h00;
                        outValid_q <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (holdCnt_q != '0) begin
                        holdCnt_q <= holdCnt_q - HW'(1);
                    end else if (GAP_CYCLES > 0) begin
                        outLines_q <= 8'h00;
                        outValid_q <= 1'b0;
                        gapCnt_q   <= GAP_LOAD;
                        state_q    <= GAP;
                    end else if (pop) begin
                        outLines_q <= 8'b1 << headCode;
                        outValid_q <= 1'b1;
                        holdCnt_q  <= HOLD_LOAD;
                    end else begin
                        outLines_q <= 8'h00;
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                GAP: begin
                    if (gapCnt_q != '0) begin
                        gapCnt_q <= gapCnt_q - GW'(1);
                    end else if (pop) begin
                        outLines_q <= 8'b1 << headCode;
                        outValid_q <= 1'b1;
                        holdCnt_q  <= HOLD_LOAD;
                        state_q    <= DRIVE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    outLines_q <= 8'h00;
                    outValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign lineIf.in_ready  = !fifoFull;
    assign lineIf.out_lines = outLines_q;
    assign lineIf.out_valid = outValid_q;
    assign lineIf.busy      = !fifoEmpty || (state_q != IDLE);

endmodule

// File: tb/tb_decoder_3_to_8_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder_3_to_8_seq
// Drives two decoders with identical stimulus: dutA with the default timing
// (hold 4, gap 1) and dutB with hold 1, gap 0. A slot-based reference model
// (a queue of codes plus "cycles since launch") predicts every output each
// cycle; a scoreboard compares dutA's pulse order to the accepted codes.
// ---------------------------------------------------------------------------
module tb_decoder_3_to_8_seq;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    decoder_3_to_8_seq_if ifA ();
    decoder_3_to_8_seq_if ifB ();

    decoder_3_to_8_seq #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(4), .GAP_CYCLES(1)) dutA (
        .clk    (clk),
        .rst    (rst),
        .lineIf (ifA)
    );

    decoder_3_to_8_seq #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dutB (
        .clk    (clk),
        .rst    (rst),
        .lineIf (ifB)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per decoder, a queue of waiting codes and the number
    // of cycles the current slot (pulse + gap) has been running.
    int         mHold [2] = '{4, 1};
    int         mGap  [2] = '{1, 0};
    bit         mActive [2];
    int         mElapsed [2];
    logic [2:0] mCode [2];
    logic [2:0] qA [$];
    logic [2:0] qB [$];

    logic [2:0] acceptedA [$];
    logic [2:0] seenA [$];
    logic       prevValidA;

    function automatic int qSize(input int m);
        return (m == 0) ? qA.size() : qB.size();
    endfunction

    function automatic logic [7:0] expLines(input int m);
        if (mActive[m] && (mElapsed[m] <= mHold[m])) begin
            return 8'd1 << mCode[m];
        end
        return 8'd0;
    endfunction

    task automatic modelReset();
        qA.delete();
        qB.delete();
        acceptedA.delete();
        seenA.delete();
        prevValidA = 1'b0;
        for (int m = 0; m < 2; m++) begin
            mActive[m]  = 1'b0;
            mElapsed[m] = 0;
            mCode[m]    = 3'd0;
        end
    endtask

    // One clock edge of the model: launch decisions use the queue as it was
    // before the edge, then an accepted code is appended.
    task automatic modelStep(input int m, input logic v, input logic [2:0] c,
                             input logic en, output bit acc);
        int size;
        bit decide;
        size   = qSize(m);
        acc    = v && (size < DEPTH);
        decide = !mActive[m] || (mElapsed[m] == mHold[m] + mGap[m]);
        if (!decide) begin
            mElapsed[m]++;
        end else if (size > 0 && en) begin
            if (m == 0) mCode[m] = qA.pop_front();
            else        mCode[m] = qB.pop_front();
            mActive[m]  = 1'b1;
            mElapsed[m] = 1;
        end else begin
            mActive[m] = 1'b0;
        end
        if (acc) begin
            if (m == 0) qA.push_back(c);
            else        qB.push_back(c);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkDut(input int m);
        logic [7:0] lines;
        logic       valid;
        logic       busyS;
        logic       ready;
        if (m == 0) begin
            lines = ifA.out_lines; valid = ifA.out_valid; busyS = ifA.busy; ready = ifA.in_ready;
        end else begin
            lines = ifB.out_lines; valid = ifB.out_valid; busyS = ifB.busy; ready = ifB.in_ready;
        end
        checkOutput($sformatf("dut%0d_lines", m), 32'(lines), 32'(expLines(m)));
        checkOutput($sformatf("dut%0d_valid", m), 32'(valid), 32'(expLines(m) != 8'd0));
        checkOutput($sformatf("dut%0d_busy", m), 32'(busyS), 32'(mActive[m] || qSize(m) > 0));
        checkOutput($sformatf("dut%0d_ready", m), 32'(ready), 32'(qSize(m) < DEPTH));
        checkOutput($sformatf("dut%0d_onehot", m), 32'($countones(lines) <= 1), 32'd1);
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] c, input logic en);
        ifA.in_valid = v;  ifA.in_code = c;  ifA.enable = en;
        ifB.in_valid = v;  ifB.in_code = c;  ifB.enable = en;
    endtask

    // Advance one clock: step the model at the edge, sample the DUTs 1ns later.
    task automatic tick(output bit accA);
        bit accB;
        @(posedge clk);
        if (rst) begin
            modelReset();
            accA = 1'b0;
        end else begin
            modelStep(0, ifA.in_valid, ifA.in_code, ifA.enable, accA);
            modelStep(1, ifB.in_valid, ifB.in_code, ifB.enable, accB);
            if (accA) acceptedA.push_back(ifA.in_code);
        end
        #1;
        checkDut(0);
        checkDut(1);
        if (ifA.out_valid && !prevValidA) begin
            for (int i = 0; i < 8; i++) begin
                if (ifA.out_lines[i]) seenA.push_back(3'(i));
            end
        end
        prevValidA = ifA.out_valid;
    endtask

    // Hold a code on the bus until dutA takes it (bounded).
    task automatic pushCode(input logic [2:0] c, input logic en);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        applyStimulus(1'b1, c, en);
        while (!acc && n < 60) begin
            tick(acc);
            n++;
        end
        checkOutput($sformatf("push_%0d_accepted", c), 32'(acc), 32'd1);
        applyStimulus(1'b0, c, en);
    endtask

    initial begin
        bit acc;
        int sent;
        int guard;
        bit sawStall;
        int stalled;
        int nCmp;

        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0);
        modelReset();
        repeat (2) tick(acc);
        rst = 1'b0;

        // Single pulse of code 5 with default timing
        applyStimulus(1'b0, 3'd0, 1'b1);
        repeat (2) tick(acc);
        applyStimulus(1'b1, 3'd5, 1'b1);
        tick(acc);
        applyStimulus(1'b0, 3'd0, 1'b1);
        tick(acc);
        checkOutput("t1_launch", 32'(ifA.out_lines), 32'h20);
        repeat (3) tick(acc);
        checkOutput("t1_hold_last", 32'(ifA.out_lines), 32'h20);
        tick(acc);
        checkOutput("t1_gap_zero", 32'(ifA.out_lines), 32'h00);
        tick(acc);
        checkOutput("t1_busy_fall", 32'(ifA.busy), 32'd0);

        // Codes 0..7 streamed back-to-back
        sent = 0;
        guard = 0;
        sawStall = 1'b0;
        applyStimulus(1'b1, 3'd0, 1'b1);
        while (sent < 8 && guard < 200) begin
            tick(acc);
            if (acc) sent++;
            if (!ifA.in_ready) sawStall = 1'b1;
            guard++;
            applyStimulus(sent < 8, 3'(sent), 1'b1);
        end
        checkOutput("t2_all_accepted", 32'(sent), 32'd8);
        checkOutput("t2_ready_dropped", 32'(sawStall), 32'd1);
        applyStimulus(1'b0, 3'd0, 1'b1);
        repeat (45) tick(acc);

        // Buffering while disabled, then release
        pushCode(3'd3, 1'b0);
        pushCode(3'd6, 1'b0);
        checkOutput("t3_lines_idle", 32'(ifA.out_lines), 32'h00);
        checkOutput("t3_busy", 32'(ifA.busy), 32'd1);
        pushCode(3'd1, 1'b0);
        pushCode(3'd4, 1'b0);
        checkOutput("t3_full", 32'(ifA.in_ready), 32'd0);
        stalled = 0;
        applyStimulus(1'b1, 3'd2, 1'b0);
        repeat (3) begin
            tick(acc);
            if (!acc) stalled++;
        end
        checkOutput("t3_fifth_stalls", 32'(stalled), 32'd3);
        pushCode(3'd2, 1'b1);
        applyStimulus(1'b0, 3'd0, 1'b1);
        repeat (35) tick(acc);

        // Asynchronous reset in the middle of a pulse with codes buffered
        pushCode(3'd7, 1'b1);
        pushCode(3'd1, 1'b1);
        pushCode(3'd2, 1'b1);
        pushCode(3'd3, 1'b1);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("t4_async_lines", 32'(ifA.out_lines), 32'h00);
        checkOutput("t4_async_ready", 32'(ifA.in_ready), 32'd1);
        checkDut(0);
        checkDut(1);
        repeat (2) tick(acc);
        rst = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b1);
        repeat (10) tick(acc);

        // Back-to-back single-cycle pulses on dutB
        pushCode(3'd1, 1'b1);
        pushCode(3'd2, 1'b1);
        checkOutput("t5_b_first", 32'(ifB.out_lines), 32'h02);
        pushCode(3'd3, 1'b1);
        checkOutput("t5_b_second", 32'(ifB.out_lines), 32'h04);
        tick(acc);
        checkOutput("t5_b_third", 32'(ifB.out_lines), 32'h08);
        repeat (20) tick(acc);

        // Random traffic keeping the buffer mostly full, enable mostly high
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 9) != 0);
            tick(acc);
        end
        applyStimulus(1'b0, 3'd0, 1'b1);
        repeat (60) tick(acc);

        // Pulse order on dutA against accepted codes
        checkOutput("sb_count", 32'(seenA.size()), 32'(acceptedA.size()));
        nCmp = (seenA.size() < acceptedA.size()) ? seenA.size() : acceptedA.size();
        for (int i = 0; i < nCmp; i++) begin
            checkOutput($sformatf("sb_order_%0d", i), 32'(seenA[i]), 32'(acceptedA[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
